// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, word-alignment states and the token matcher.
package tmds_pkg;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} align_state_t;

    // Returns {hit, code}; code is 0 when there is no hit.
    function automatic logic [2:0] is_ctrl_token(input logic [9:0] w);
        return w == TOK_00 ? 3'b100 :
               w == TOK_01 ? 3'b101 :
               w == TOK_10 ? 3'b110 :
               w == TOK_11 ? 3'b111 : 3'b000;
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// tmds_word_aligner: hunts for the 10-bit word boundary using control tokens.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT   = 8,
    parameter int SEARCH_DWELL = 16,
    parameter int LOSS_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] d_in,
    output logic [9:0] window,
    output logic       is_token,
    output logic [1:0] token_code,
    output logic       locked,
    output logic       lock_next,
    output logic [3:0] bit_offset
);
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);
    localparam int DW = $clog2(SEARCH_DWELL + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);

    logic [9:0]   cur, prev;
    logic [19:0]  pair;
    logic [3:0]   off_inc, off_nxt;
    align_state_t state, state_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic [MW-1:0] match_cnt, match_nxt;
    logic [LW-1:0] loss_cnt, loss_nxt;

    assign pair = {cur, prev};
    assign window = 10'(pair >> bit_offset);
    assign {is_token, token_code} = is_ctrl_token(window);
    assign off_inc = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
    assign locked = state == LOCKED;
    // The output stage registers alongside the state, so it needs the upcoming lock status.
    assign lock_next = state_nxt == LOCKED;

    always_comb begin
        state_nxt = state;
        off_nxt   = bit_offset;
        dwell_nxt = dwell_cnt;
        match_nxt = match_cnt;
        loss_nxt  = loss_cnt;
        case (state)
            SEARCH:
                if (is_token) begin
                    state_nxt = VERIFY;
                    match_nxt = MW'(1);
                    dwell_nxt = '0;
                end else if (dwell_cnt == DW'(SEARCH_DWELL - 1)) begin
                    off_nxt   = off_inc;
                    dwell_nxt = '0;
                end else
                    dwell_nxt = dwell_cnt + 1'b1;
            VERIFY:
                if (is_token) begin
                    match_nxt = match_cnt + 1'b1;
                    if (match_nxt == MW'(LOCK_COUNT)) begin
                        state_nxt = LOCKED;
                        loss_nxt  = '0;
                    end
                end else begin
                    state_nxt = SEARCH;
                    off_nxt   = off_inc;
                    dwell_nxt = '0;
                end
            LOCKED:
                if (is_token)
                    loss_nxt = '0;
                else if (loss_cnt == LW'(LOSS_TIMEOUT - 1)) begin
                    state_nxt = SEARCH;
                    off_nxt   = off_inc;
                    dwell_nxt = '0;
                end else
                    loss_nxt = loss_cnt + 1'b1;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cur        <= '0;
            prev       <= '0;
            state      <= SEARCH;
            bit_offset <= '0;
            dwell_cnt  <= '0;
            match_cnt  <= '0;
            loss_cnt   <= '0;
        end else begin
            cur        <= d_in;
            prev       <= cur;
            state      <= state_nxt;
            bit_offset <= off_nxt;
            dwell_cnt  <= dwell_nxt;
            match_cnt  <= match_nxt;
            loss_cnt   <= loss_nxt;
        end

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: TMDS 10b->8b channel decoder with word alignment.
// Define TMDS_ERR_CHECK_EN to add running-disparity checking and the disp_err port.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT   = 8,
    parameter int SEARCH_DWELL = 16,
    parameter int LOSS_TIMEOUT = 65535,
    parameter int DISP_LIMIT   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] d_in,
    output logic [7:0] d_out,
    output logic [1:0] control,
    output logic       disp_ena,
    output logic       locked,
    output logic [3:0] bit_offset
`ifdef TMDS_ERR_CHECK_EN
    ,
    output logic       disp_err
`endif
);
    logic [9:0] window;
    logic       is_token, lock_next;
    logic [1:0] token_code;
    logic [7:0] q, dec;

    tmds_word_aligner #(
        .LOCK_COUNT  (LOCK_COUNT),
        .SEARCH_DWELL(SEARCH_DWELL),
        .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) u_aligner (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .window    (window),
        .is_token  (is_token),
        .token_code(token_code),
        .locked    (locked),
        .lock_next (lock_next),
        .bit_offset(bit_offset)
    );

    assign q = window[9] ? ~window[7:0] : window[7:0];
    // window[8]=0 marks the XNOR chain, hence the extra inversion.
    assign dec = {q[7:1] ^ q[6:0] ^ {7{~window[8]}}, q[0]};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            d_out    <= '0;
            control  <= '0;
            disp_ena <= 1'b0;
        end else begin
            d_out    <= (lock_next && !is_token) ? dec : 8'd0;
            disp_ena <= lock_next && !is_token;
            control  <= !lock_next ? 2'd0 : is_token ? token_code : control;
        end

`ifdef TMDS_ERR_CHECK_EN
    logic        [3:0] ones;
    logic signed [5:0] rd, rd_sat;
    logic signed [6:0] rd_sum;
    logic        [5:0] rd_abs;

    assign ones   = 4'($countones(window));
    assign rd_sum = $signed({rd[5], rd}) + $signed({2'b00, ones, 1'b0}) - 7'sd10;
    assign rd_sat = rd_sum > 7'sd31 ? 6'sd31 : rd_sum < -7'sd31 ? -6'sd31 : rd_sum[5:0];
    assign rd_abs = rd_sat[5] ? 6'(-rd_sat) : rd_sat;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd       <= '0;
            disp_err <= 1'b0;
        end else begin
            rd       <= (!lock_next || is_token) ? 6'sd0 : rd_sat;
            disp_err <= lock_next && !is_token && rd_abs > 6'(DISP_LIMIT);
        end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: scoreboard bench for tmds_decoder against a bit-stream reference model.
module tb_tmds_decoder;
    localparam int LK = 8, DWL = 16, LT = 300, DL = 10;

    logic       clk = 1'b0, rst = 1'b1;
    logic [9:0] d_in = '0;
    logic [7:0] d_out;
    logic [1:0] control;
    logic       disp_ena, locked, err_bit;
    logic [3:0] bit_offset;
`ifdef TMDS_ERR_CHECK_EN
    logic       disp_err;
    assign err_bit = disp_err;
`else
    assign err_bit = 1'b0;
`endif

    tmds_decoder #(.LOCK_COUNT(LK), .SEARCH_DWELL(DWL), .LOSS_TIMEOUT(LT), .DISP_LIMIT(DL)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .d_out(d_out), .control(control),
        .disp_ena(disp_ena), .locked(locked), .bit_offset(bit_offset)
`ifdef TMDS_ERR_CHECK_EN
        , .disp_err(disp_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit mon_en = 0;
    logic [16:0] expq[$];
    logic [9:0] tok[4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Reference model: the received bit stream, positions 0..19 standing for the cleared registers.
    bit stream[$];
    int mst, moff, mdwell, mmatch, mloss, mrd;
    logic [1:0] mctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        stream.delete();
        for (int i = 0; i < 20; i++) stream.push_back(1'b0);
        mst = 0; moff = 0; mdwell = 0; mmatch = 0; mloss = 0; mrd = 0; mctrl = 2'd0;
    endtask

    task automatic model_step(input logic [9:0] w, output logic [16:0] e);
        logic [9:0] win;
        logic [7:0] q, dec;
        logic [1:0] code;
        bit hit, lk, err;
        int base, ones;
        hit = 0; code = 0; err = 0;
        base = stream.size() - 20;
        for (int j = 0; j < 10; j++) win[j] = stream[base + moff + j];
        for (int c = 0; c < 4; c++) if (win == tok[c]) begin hit = 1; code = 2'(c); end
        q = win[9] ? ~win[7:0] : win[7:0];
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) dec[i] = win[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
        if (mst == 0) begin
            if (hit) begin mst = 1; mmatch = 1; mdwell = 0; end
            else begin
                mdwell++;
                if (mdwell == DWL) begin moff = (moff + 1) % 10; mdwell = 0; end
            end
        end else if (mst == 1) begin
            if (hit) begin
                mmatch++;
                if (mmatch == LK) begin mst = 2; mloss = 0; end
            end else begin mst = 0; moff = (moff + 1) % 10; mdwell = 0; end
        end else if (hit) mloss = 0;
        else begin
            mloss++;
            if (mloss == LT) begin mst = 0; moff = (moff + 1) % 10; mdwell = 0; end
        end
        lk = (mst == 2);
        ones = $countones(win);
        if (!lk) begin
            mctrl = 0; mrd = 0;
            e = {8'h00, 2'd0, 1'b0, 1'b0, 4'(moff), 1'b0};
        end else if (hit) begin
            mctrl = code; mrd = 0;
            e = {8'h00, code, 1'b0, 1'b1, 4'(moff), 1'b0};
        end else begin
            mrd = mrd + 2 * ones - 10;
            if (mrd > 31) mrd = 31;
            if (mrd < -31) mrd = -31;
`ifdef TMDS_ERR_CHECK_EN
            err = (mrd > DL) || (mrd < -DL);
`endif
            e = {dec, mctrl, 1'b1, 1'b1, 4'(moff), err};
        end
        for (int b = 0; b < 10; b++) stream.push_back(w[b]);
    endtask

    function automatic logic [9:0] rot(input logic [9:0] t, input int r);
        logic [9:0] o;
        for (int b = 0; b < 10; b++) o[b] = t[(b + 10 - r) % 10];
        return o;
    endfunction

    task automatic drive(input logic [9:0] w);
        logic [16:0] e;
        d_in = w;
        model_step(w, e);
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("async_reset", {d_out, control, disp_ena, locked, bit_offset, err_bit}, 0);
        mon_en = 0;
        expq.delete();
        model_reset();
        d_in = '0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (expq.size() > 0)
                check("scoreboard", {d_out, control, disp_ena, locked, bit_offset, err_bit}, expq.pop_front());
            else
                check("underflow", 1, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int r, c;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {d_out, control, disp_ena, locked, bit_offset}, 0);
        rst = 1'b0;
        mon_en = 1;

        repeat (LK + 2) drive(tok[0]);
        check("lock_aligned", {locked, bit_offset, control, disp_ena}, {1'b1, 4'd0, 2'd0, 1'b0});
        drive(10'b0100000000);
        drive(10'b1000000000);
        drive(tok[0]);
        check("data_00", {d_out, disp_ena, control}, {8'h00, 1'b1, 2'd0});
        drive(tok[0]);
        check("data_ff", {d_out, disp_ena, control}, {8'hFF, 1'b1, 2'd0});
        repeat (200) drive(($urandom % 8 == 0) ? tok[0] : 10'($urandom));

        do_reset();
        repeat (120) drive(rot(tok[1], 3));
        check("lock_rot3", {locked, bit_offset, control}, {1'b1, 4'd3, 2'd1});
        do_reset();
        repeat (55) drive(rot(tok[1], 3));
        do_reset();

        repeat (200) drive(rot(tok[2], 9));
        check("lock_rot9", {locked, bit_offset, control}, {1'b1, 4'd9, 2'd2});
        repeat (LT + 5) drive(10'b0100000000);
        check("loss_wrap", {locked, bit_offset}, {1'b0, 4'd0});

        for (int k = 0; k < 4; k++) begin
            do_reset();
            r = $urandom_range(0, 9);
            c = $urandom_range(0, 3);
            repeat (200) drive(rot(tok[c], r));
            repeat (300) drive(($urandom % 6 == 0) ? rot(tok[c], r) : 10'($urandom));
        end

`ifdef TMDS_ERR_CHECK_EN
        do_reset();
        repeat (LK + 2) drive(tok[0]);
        repeat (3) drive(10'b1111111100);
        check("disp_first", {31'd0, err_bit}, 0);
        drive(10'b1111111100);
        check("disp_second", {31'd0, err_bit}, 1);
        repeat (3) drive(tok[0]);
        check("disp_clear", {31'd0, err_bit}, 0);
`endif

        mon_en = 0;
        check("queue_drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
